// File: rtl/axi_arbiter_nport.sv
// axi_arbiter_nport: N-master to 1-slave AXI-lite style arbiter.
// One transaction outstanding at a time. Within a master, a pending write
// is served before a pending read. Slave-side address and data are pure
// muxes on grant_idx; only handshakes are gated by the FSM state.
// Build option: define AXI_ARB_RR_EN for round-robin arbitration; when it
// is undefined, fixed priority applies and the highest index wins.
module axi_arbiter_nport #(
   parameter int N_MST  = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   // master side
   input  logic [N_MST*ADDR_W-1:0]         m_AW_ADDR,
   input  logic [N_MST*ADDR_W-1:0]         m_AR_ADDR,
   input  logic [N_MST-1:0]                m_AW_VALID,
   input  logic [N_MST-1:0]                m_W_VALID,
   input  logic [N_MST-1:0]                m_AR_VALID,
   input  logic [N_MST-1:0]                m_B_READY,
   input  logic [N_MST-1:0]                m_R_READY,
   output logic [N_MST-1:0]                m_AW_READY,
   output logic [N_MST-1:0]                m_W_READY,
   output logic [N_MST-1:0]                m_AR_READY,
   output logic [N_MST-1:0]                m_B_VALID,
   output logic [N_MST-1:0]                m_R_VALID,
   input  logic [N_MST*DATA_W-1:0]         m_W_DATA,
   input  logic [N_MST*(DATA_W/8)-1:0]     m_W_STRB,
   output logic [N_MST*DATA_W-1:0]         m_R_DATA,
   // slave side
   output logic [ADDR_W-1:0]               s_AW_ADDR,
   output logic [ADDR_W-1:0]               s_AR_ADDR,
   output logic [DATA_W-1:0]               s_W_DATA,
   output logic [DATA_W/8-1:0]             s_W_STRB,
   output logic                            s_AW_VALID,
   output logic                            s_W_VALID,
   output logic                            s_AR_VALID,
   output logic                            s_B_READY,
   output logic                            s_R_READY,
   input  logic                            s_AW_READY,
   input  logic                            s_W_READY,
   input  logic                            s_AR_READY,
   input  logic                            s_B_VALID,
   input  logic                            s_R_VALID,
   input  logic [DATA_W-1:0]               s_R_DATA,
   // status
   output logic [$clog2(N_MST)-1:0]        grant_idx,
   output logic                            busy
);
   localparam int STRB_W = DATA_W/8;
   localparam int GW     = $clog2(N_MST);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

   state_t           state_q;
   logic [GW-1:0]    grant_q;
   logic [GW-1:0]    win_d;
   logic [N_MST-1:0] req;
   logic             rd_done, wr_done;

   assign req     = m_AR_VALID | m_AW_VALID;
   assign rd_done = (state_q == S_R) && s_R_VALID && m_R_READY[grant_q];
   assign wr_done = (state_q == S_B) && s_B_VALID && m_B_READY[grant_q];

`ifdef AXI_ARB_RR_EN
   logic [GW-1:0] ptr_q;

   // Round-robin pick: first requester found scanning upward from the pointer.
   always_comb begin
      int   idx;
      logic found;
      win_d = grant_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_MST; k++) begin
         idx = (int'(ptr_q) + k) % N_MST;
         if (!found && req[idx]) begin
            win_d = GW'(idx);
            found = 1'b1;
         end
      end
   end

   // Pointer advances past the owner only once its transaction has finished.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (rd_done || wr_done)
         ptr_q <= (grant_q == GW'(N_MST-1)) ? '0 : grant_q + 1'b1;
   end
`else
   // Fixed priority pick: later (higher) index overrides lower ones.
   always_comb begin
      win_d = grant_q;
      for (int i = 0; i < N_MST; i++)
         if (req[i]) win_d = GW'(i);
   end
`endif

   // Transaction FSM; grant is latched on leaving IDLE and held to completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (|req) begin
               grant_q <= win_d;
               state_q <= m_AW_VALID[win_d] ? S_AW : S_AR;
            end
            S_AR:   if (m_AR_VALID[grant_q] && s_AR_READY) state_q <= S_R;
            S_R:    if (rd_done)                           state_q <= S_IDLE;
            S_AW:   if (m_AW_VALID[grant_q] && s_AW_READY) state_q <= S_W;
            S_W:    if (m_W_VALID[grant_q] && s_W_READY)   state_q <= S_B;
            S_B:    if (wr_done)                           state_q <= S_IDLE;
            default:                                       state_q <= S_IDLE;
         endcase
      end
   end

   // Handshake routing: only the channel owned by the current state is live.
   always_comb begin
      m_AW_READY = '0;
      m_W_READY  = '0;
      m_AR_READY = '0;
      m_B_VALID  = '0;
      m_R_VALID  = '0;
      s_AW_VALID = 1'b0;
      s_W_VALID  = 1'b0;
      s_AR_VALID = 1'b0;
      s_B_READY  = 1'b0;
      s_R_READY  = 1'b0;
      case (state_q)
         S_AR: begin
            s_AR_VALID          = m_AR_VALID[grant_q];
            m_AR_READY[grant_q] = s_AR_READY;
         end
         S_R: begin
            m_R_VALID[grant_q]  = s_R_VALID;
            s_R_READY           = m_R_READY[grant_q];
         end
         S_AW: begin
            s_AW_VALID          = m_AW_VALID[grant_q];
            m_AW_READY[grant_q] = s_AW_READY;
         end
         S_W: begin
            s_W_VALID           = m_W_VALID[grant_q];
            m_W_READY[grant_q]  = s_W_READY;
         end
         S_B: begin
            m_B_VALID[grant_q]  = s_B_VALID;
            s_B_READY           = m_B_READY[grant_q];
         end
         default: ;
      endcase
   end

   assign s_AW_ADDR = m_AW_ADDR[int'(grant_q)*ADDR_W +: ADDR_W];
   assign s_AR_ADDR = m_AR_ADDR[int'(grant_q)*ADDR_W +: ADDR_W];
   assign s_W_DATA  = m_W_DATA[int'(grant_q)*DATA_W +: DATA_W];
   assign s_W_STRB  = m_W_STRB[int'(grant_q)*STRB_W +: STRB_W];
   assign m_R_DATA  = {N_MST{s_R_DATA}};
   assign grant_idx = grant_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/axi_arbiter_nport.md
AXI_ARBITER_NPORT -- requirements
Module: axi_arbiter_nport

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of master ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, address width.
REQ-003 SHALL have parameter DATA_W, default 64, data width; strobe width STRB_W = DATA_W/8.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports m_AW_ADDR / m_AR_ADDR  in  N_MST*ADDR_W  master addresses, master i at slice [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have ports m_AW_VALID / m_W_VALID / m_AR_VALID / m_B_READY / m_R_READY  in  N_MST  per-master handshakes.
REQ-008 SHALL have ports m_AW_READY / m_W_READY / m_AR_READY / m_B_VALID / m_R_VALID  out  N_MST  per-master handshakes.
REQ-009 SHALL have ports m_W_DATA  in  N_MST*DATA_W  and  m_W_STRB  in  N_MST*STRB_W  write data and strobes.
REQ-010 SHALL have port m_R_DATA  out  N_MST*DATA_W  read data, broadcast to every slice.
REQ-011 SHALL have ports s_AW_ADDR / s_AR_ADDR  out  ADDR_W;  s_W_DATA  out  DATA_W;  s_W_STRB  out  STRB_W  slave side.
REQ-012 SHALL have ports s_AW_VALID / s_W_VALID / s_AR_VALID / s_B_READY / s_R_READY  out  1  and  s_AW_READY / s_W_READY / s_AR_READY / s_B_VALID / s_R_VALID  in  1;  s_R_DATA  in  DATA_W.
REQ-013 SHALL have ports grant_idx  out  $clog2(N_MST)  current owner, and busy  out  1  high when not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, AR, R, AW, W, B, with one transaction outstanding at a time.
REQ-015 In IDLE, master i requests when m_AR_VALID[i] | m_AW_VALID[i]; the winner SHALL be registered into grant_idx, and the FSM SHALL move on the next edge to AW if that master's AW_VALID=1, else to AR (write before read within one master).
REQ-016 AR SHALL route the owner's AR_ADDR/AR_VALID to the slave and s_AR_READY to the owner only; on handshake go to R.
REQ-017 R SHALL route s_R_VALID to the owner only and the owner's R_READY to s_R_READY; on handshake return to IDLE.
REQ-018 AW then W then B SHALL route their channels the same way; on B handshake return to IDLE.
REQ-019 Non-owner READY/VALID outputs SHALL be 0; slave VALID/READY outputs SHALL be 0 in IDLE and in states not owning that channel.
REQ-020 Slave address/data outputs SHALL be combinational muxes of grant_idx; no data buffering.
REQ-021 Minimum turnaround SHALL be one IDLE cycle between transactions; a read SHALL take at least 3 cycles from grant (IDLE, AR, R).
REQ-022 Slave R/B VALID arriving in a non-matching state SHALL be ignored (READY held 0).
REQ-023 Masters SHALL hold VALID until handshake; if an owner drops VALID, the arbiter SHALL wait in the current state without timeout.
REQ-024 No requests SHALL leave the FSM in IDLE with grant_idx unchanged.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, grant_idx=0, RR pointer=0, busy=0, and all VALID/READY outputs 0, including mid-transaction; data outputs are don't-care.
REQ-026 First arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro AXI_ARB_RR_EN defined: round-robin; search starts at pointer, and pointer := grant_idx+1 mod N_MST on transaction completion.
REQ-028 AXI_ARB_RR_EN undefined: fixed priority, highest index wins (data-side master above fetch), pointer logic absent.

Verification
REQ-029 Reset, N_MST=2, no requests -> busy=0, all slave VALIDs 0 for 20 cycles.
REQ-030 Master1 AR 0x8000_0000, slave returns R_DATA 0x1122334455667788 after 2 waits -> m_R_VALID=2'b10, data matches, FSM back in IDLE the cycle after.
REQ-031 N_MST=4, RR, all masters read continuously -> grant order 0,1,2,3,0; fixed priority -> master 3 repeatedly.
REQ-032 Master0 AW 0x100 + W 0xDEAD with STRB 0x0F and AR simultaneously -> write completes first (B), then read.
REQ-033 rst_n pulsed low during state W -> outputs 0 asynchronously, no B forwarded, next grant after release.
REQ-034 Spurious s_R_VALID=1 during AW -> s_R_READY=0, no m_R_VALID asserted.
